// File: rtl/dice_roll_arbiter.sv
// Round-robin owner of one shared serial-in/parallel-out receiver: grant, start pulse,
// wait for valid (or time out), then return the 7-bit roll with a one-cycle done pulse.
module dice_roll_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [NUM_REQ-1:0] o_done,
  output logic [6:0]         o_result,
  output logic               o_timeout,
  output logic               o_busy,
  output logic               o_sipo_start,
  input  logic               i_sipo_valid,
  input  logic [6:0]         i_sipo_data
);

  localparam int IDXW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t            state;
  logic [IDXW-1:0]   last_owner;
  logic [15:0]       cnt;
  logic              pick_vld;
  logic [IDXW-1:0]   pick;

  // Search upward starting one past the last owner, so it ends up with lowest priority.
  always_comb begin
    int c;
    c        = 0;
    pick_vld = 1'b0;
    pick     = last_owner;
    for (int i = 1; i <= NUM_REQ; i++) begin
      c = int'(last_owner) + i;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!pick_vld && i_req[IDXW'(c)]) begin
        pick_vld = 1'b1;
        pick     = IDXW'(c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      last_owner   <= IDXW'(NUM_REQ - 1);
      cnt          <= '0;
      o_grant      <= '0;
      o_done       <= '0;
      o_result     <= '0;
      o_timeout    <= 1'b0;
      o_busy       <= 1'b0;
      o_sipo_start <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            o_grant      <= NUM_REQ'(1) << pick;
            o_sipo_start <= 1'b1;
            o_busy       <= 1'b1;
            state        <= START;
          end
        end
        START: begin
          o_sipo_start <= 1'b0;
          cnt          <= '0;
          state        <= WAIT;
        end
        WAIT: begin
          // Valid is checked first so it beats a coincident timeout.
          if (i_sipo_valid) begin
            o_result  <= i_sipo_data;
            o_timeout <= 1'b0;
            o_done    <= o_grant;
            state     <= DONE;
          end else if (cnt == 16'(TIMEOUT_CYCLES)) begin
            o_result  <= '0;
            o_timeout <= 1'b1;
            o_done    <= o_grant;
            state     <= DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DONE: begin
          for (int i = 0; i < NUM_REQ; i++)
            if (o_grant[i]) last_owner <= IDXW'(i);
          o_done    <= '0;
          o_timeout <= 1'b0;
          o_grant   <= '0;
          o_busy    <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
